// File: rtl/ibex_fetch_responder.sv
// Instruction fetch unit: drives a pipelined req/gnt/rvalid bus and buffers returned words
// in a small FIFO towards decode, discarding responses made stale by a redirect.
module ibex_fetch_responder #(
  parameter int unsigned FIFO_DEPTH = 3,
  parameter int unsigned MAX_OUTST  = 2,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        pc_set_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] pc_o,
  output logic        err_o,
  output logic        is_compressed_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic [31:0] fetch_addr;
  logic [31:0] resp_addr;
  logic [31:0] redir_addr;
  logic        redir_pend;
  entry_t      fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outst, discard;

  logic          gnt, rv, drop, push, pop, hold_old, space_n;
  logic [OW-1:0] outst_n, discard_n;
  logic [CW-1:0] count_n;
  logic [31:0]   target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Per-cycle bookkeeping; a redirect overrides FIFO and discard updates.
  always_comb begin
    gnt      = (state == REQ) && mem_gnt_i;
    rv       = mem_rvalid_i && (outst != '0);
    drop     = rv && (discard != '0);
    push     = rv && !drop && !pc_set_i;
    pop      = (count != '0) && ready_i && !pc_set_i;
    hold_old = (state == REQ) && !mem_gnt_i;
    target   = {addr_i[31:2], 2'b00};

    outst_n = outst;
    if (gnt && !rv)      outst_n = outst + OW'(1);
    else if (!gnt && rv) outst_n = outst - OW'(1);

    count_n = count;
    if (pc_set_i)        count_n = '0;
    else if (push && !pop) count_n = count + CW'(1);
    else if (!push && pop) count_n = count - CW'(1);

    space_n = ((32'(count_n) + 32'(outst_n)) < FIFO_DEPTH) && (32'(outst_n) < MAX_OUTST);

    discard_n = discard;
    if (pc_set_i)  discard_n = outst_n + (hold_old ? OW'(1) : OW'(0));
    else if (drop) discard_n = discard - OW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      fetch_addr <= BOOT_ADDR;
      resp_addr  <= BOOT_ADDR;
      redir_addr <= BOOT_ADDR;
      redir_pend <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      outst      <= '0;
      discard    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '{err: 1'b0, pc: BOOT_ADDR, data: 32'h0};
      end
    end else begin
      outst   <= outst_n;
      discard <= discard_n;
      count   <= count_n;

      // Pending un-granted request is never retracted; stay until granted.
      if (hold_old) state <= REQ;
      else          state <= (req_i && space_n) ? REQ : IDLE;

      if (pc_set_i && hold_old) begin
        redir_addr <= target;
        redir_pend <= 1'b1;
      end else if (pc_set_i) begin
        fetch_addr <= target;
        redir_pend <= 1'b0;
      end else if (gnt) begin
        fetch_addr <= redir_pend ? redir_addr : fetch_addr + 32'd4;
        redir_pend <= 1'b0;
      end

      if (pc_set_i)  resp_addr <= target;
      else if (push) resp_addr <= resp_addr + 32'd4;

      if (pc_set_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr] <= '{err: mem_err_i, pc: resp_addr,
                              data: mem_err_i ? 32'h0 : mem_rdata_i};
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  assign mem_req_o       = (state == REQ);
  assign mem_addr_o      = fetch_addr;
  assign busy_o          = (outst != '0) || mem_req_o;
  assign valid_o         = (count != '0);
  assign rdata_o         = fifo_q[rd_ptr].data;
  assign pc_o            = fifo_q[rd_ptr].pc;
  assign err_o           = fifo_q[rd_ptr].err;
  assign is_compressed_o = (rdata_o[1:0] != 2'b11);

endmodule
